// File: rtl/orca_pkg.sv
`default_nettype none
// ============================================================================
// Package     : orca_pkg
// Description : Shared types, FSM state encoding and MMIO offsets for the
//               NoC packet sink (router local port -> processing element).
// Revision    : 1.0 - initial release
// ============================================================================
package orca_pkg;

    localparam int c_FLIT_W = 16;
    localparam int c_WORD_W = 32;

    typedef logic [c_WORD_W-1:0] word_t;
    typedef logic [c_FLIT_W-1:0] flit_t;

    // Receive FSM encoding; the value is exported on state_out[2:0].
    typedef enum logic [2:0] {
        S_HEADER   = 3'd0,
        S_SIZE     = 3'd1,
        S_WAIT_CMD = 3'd2,
        S_COPY     = 3'd3,
        S_DONE     = 3'd4
`ifdef DEST_CHECK_EN
        ,
        S_DROP     = 3'd5
`endif
    } sink_state_t;

    // CPU-visible register map of the receive engine.
    localparam word_t c_MMIO_RECV_SIZE = 32'h2000_0014;
    localparam word_t c_MMIO_RECV_ADDR = 32'h2000_0018;
    localparam word_t c_MMIO_RECV_CMD  = 32'h2000_001C;

endpackage : orca_pkg
`default_nettype wire

// File: rtl/flit_fifo.sv
`default_nettype none
// ============================================================================
// Module      : flit_fifo
// Description : Small synchronous flit buffer in front of the packet sink.
//               Storage is a register array read at the head pointer; credit
//               is registered so it stays low while in reset and rises one
//               cycle after reset is released.
// Revision    : 1.0 - initial release
// ============================================================================
module flit_fifo #(
    parameter int FLIT_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [FLIT_WIDTH-1:0] data_i,
    output logic [FLIT_WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  credit_o
);

    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(FIFO_DEPTH);

    logic [FLIT_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [c_PTR_W-1:0]    wr_ptr_q;
    logic [c_PTR_W-1:0]    rd_ptr_q;
    logic [c_CNT_W-1:0]    count_q;
    logic [c_CNT_W-1:0]    count_d;
    logic                  credit_q;
    logic                  do_push;
    logic                  do_pop;

    assign full_o   = (count_q == c_DEPTH);
    assign empty_o  = (count_q == '0);
    assign data_o   = mem_q[rd_ptr_q];
    assign credit_o = credit_q;

    // Qualify requests and compute the next occupancy.
    always_comb begin
        do_push = push_i && !full_o;
        do_pop  = pop_i && !empty_o;
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + c_CNT_W'(1);
            2'b01:   count_d = count_q - c_CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers, occupancy and credit; pointers wrap naturally (power-of-2 depth).
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            credit_q <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + c_PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + c_PTR_W'(1);
            count_q  <= count_d;
            credit_q <= (count_d != c_DEPTH);
        end
    end

    // Flit storage; contents are don't-care once the pointers are reset.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule : flit_fifo
`default_nettype wire

// File: rtl/noc_packet_sink.sv
`default_nettype none
// ============================================================================
// Module      : noc_packet_sink
// Description : Credit-based flit receiver terminating a router local port.
//               Reads header and size flits, raises a size interrupt, waits
//               for the CPU destination address and command, then packs
//               payload flit pairs into words written to the RAM data port
//               and pulses a completion interrupt.
//               Build option DEST_CHECK_EN: packets whose header differs from
//               ADDRESS are drained without writes and counted on
//               drop_count_out.
// Revision    : 1.0 - initial release
// ============================================================================
module noc_packet_sink
    import orca_pkg::*;
#(
    parameter int          MEMORY_WIDTH = 32,
    parameter int          FLIT_WIDTH   = 16,
    parameter int          RAM_MSIZE    = 65536,
    parameter logic [31:0] ADDRESS      = 32'h0000_0000,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    rx,
    input  logic [FLIT_WIDTH-1:0]   data_i,
    output logic                    credit_o,
    input  logic [31:0]             recv_addr_in,
    input  logic                    recv_cmd_in,
    output logic [31:0]             recv_size_out,
    output logic [31:0]             recv_addr_out,
    output logic [7:0]              state_out,
    output logic                    irq_size_out,
    output logic                    irq_done_out,
    output logic [31:0]             mem_addr_out,
    output logic [MEMORY_WIDTH-1:0] mem_data_out,
    output logic [3:0]              mem_wb_out
`ifdef DEST_CHECK_EN
    ,
    output logic [15:0]             drop_count_out
`endif
);

    localparam word_t c_ADDR_MASK = 32'(RAM_MSIZE - 1);

    // ------------------------------------------------------------------
    // Input buffer
    // ------------------------------------------------------------------
    logic [FLIT_WIDTH-1:0] fifo_data;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic                  fifo_push;

    assign fifo_push = rx && credit_o && !fifo_full;

    flit_fifo #(
        .FLIT_WIDTH (FLIT_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push_i   (fifo_push),
        .pop_i    (fifo_pop),
        .data_i   (data_i),
        .data_o   (fifo_data),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .credit_o (credit_o)
    );

    // ------------------------------------------------------------------
    // Receive FSM state and registered outputs
    // ------------------------------------------------------------------
    sink_state_t             state_q,    state_d;
    word_t                   size_q,     size_d;
    word_t                   addr_q,     addr_d;
    word_t                   remain_q,   remain_d;
    logic                    half_q,     half_d;
    logic [FLIT_WIDTH-1:0]   hi_q,       hi_d;
    logic                    irq_size_q, irq_size_d;
    logic                    irq_done_q, irq_done_d;
    word_t                   mem_addr_q, mem_addr_d;
    logic [MEMORY_WIDTH-1:0] mem_data_q, mem_data_d;
    logic [3:0]              mem_wb_q,   mem_wb_d;
`ifdef DEST_CHECK_EN
    logic                    bad_q,      bad_d;
    logic [15:0]             drop_q,     drop_d;
`endif

    logic                    do_write;
    logic [MEMORY_WIDTH-1:0] write_word;
    word_t                   flit_zext;

    assign flit_zext = {{(32-FLIT_WIDTH){1'b0}}, fifo_data};

    // Next-state, flit consumption and write-request decode.
    always_comb begin
        state_d    = state_q;
        size_d     = size_q;
        addr_d     = addr_q;
        remain_d   = remain_q;
        half_d     = half_q;
        hi_d       = hi_q;
        irq_size_d = irq_size_q;
        irq_done_d = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        mem_wb_d   = 4'h0;
        fifo_pop   = 1'b0;
        do_write   = 1'b0;
        write_word = '0;
`ifdef DEST_CHECK_EN
        bad_d      = bad_q;
        drop_d     = drop_q;
`endif

        case (state_q)
            S_HEADER: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = S_SIZE;
`ifdef DEST_CHECK_EN
                    bad_d    = (fifo_data[15:0] != ADDRESS[15:0]);
`endif
                end
            end

            S_SIZE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    size_d   = flit_zext;
`ifdef DEST_CHECK_EN
                    if (bad_q) begin
                        // Foreign packet: drain its payload silently.
                        remain_d = flit_zext;
                        state_d  = (flit_zext == '0) ? S_HEADER : S_DROP;
                        if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
                    end else begin
                        state_d    = S_WAIT_CMD;
                        irq_size_d = 1'b1;
                    end
`else
                    state_d    = S_WAIT_CMD;
                    irq_size_d = 1'b1;
`endif
                end
            end

            S_WAIT_CMD: begin
                if (recv_cmd_in) begin
                    addr_d     = recv_addr_in;
                    irq_size_d = 1'b0;
                    remain_d   = size_q;
                    half_d     = 1'b0;
                    if (size_q == '0) begin
                        state_d    = S_DONE;
                        irq_done_d = 1'b1;
                    end else begin
                        state_d = S_COPY;
                    end
                end
            end

            S_COPY: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    remain_d = remain_q - 32'd1;
                    if (!half_q) begin
                        if (remain_q == 32'd1) begin
                            // Lone final flit of an odd-size packet.
                            do_write   = 1'b1;
                            write_word = {fifo_data, {FLIT_WIDTH{1'b0}}};
                        end else begin
                            hi_d   = fifo_data;
                            half_d = 1'b1;
                        end
                    end else begin
                        do_write   = 1'b1;
                        write_word = {hi_q, fifo_data};
                        half_d     = 1'b0;
                    end
                    if (remain_q == 32'd1) begin
                        state_d    = S_DONE;
                        irq_done_d = 1'b1;
                        half_d     = 1'b0;
                    end
                end
            end

            S_DONE: begin
                state_d = S_HEADER;
            end

`ifdef DEST_CHECK_EN
            S_DROP: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    remain_d = remain_q - 32'd1;
                    if (remain_q == 32'd1) state_d = S_HEADER;
                end
            end
`endif

            default: begin
                state_d = S_HEADER;
            end
        endcase

        if (do_write) begin
            mem_addr_d = (addr_q & c_ADDR_MASK) >> 2;
            mem_data_d = write_word;
            mem_wb_d   = 4'hF;
            addr_d     = addr_q + 32'd4;
        end
    end

    // State and output registers; reset drops any partial packet.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_HEADER;
            size_q     <= '0;
            addr_q     <= '0;
            remain_q   <= '0;
            half_q     <= 1'b0;
            hi_q       <= '0;
            irq_size_q <= 1'b0;
            irq_done_q <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_wb_q   <= 4'h0;
`ifdef DEST_CHECK_EN
            bad_q      <= 1'b0;
            drop_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            size_q     <= size_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            half_q     <= half_d;
            hi_q       <= hi_d;
            irq_size_q <= irq_size_d;
            irq_done_q <= irq_done_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            mem_wb_q   <= mem_wb_d;
`ifdef DEST_CHECK_EN
            bad_q      <= bad_d;
            drop_q     <= drop_d;
`endif
        end
    end

    assign recv_size_out = size_q;
    assign recv_addr_out = addr_q;
    assign state_out     = {5'b0, state_q};
    assign irq_size_out  = irq_size_q;
    assign irq_done_out  = irq_done_q;
    assign mem_addr_out  = mem_addr_q;
    assign mem_data_out  = mem_data_q;
    assign mem_wb_out    = mem_wb_q;
`ifdef DEST_CHECK_EN
    assign drop_count_out = drop_q;
`endif

endmodule : noc_packet_sink
`default_nettype wire

// File: tb/tb_noc_packet_sink.sv
`default_nettype none
// ============================================================================
// Module      : tb_noc_packet_sink
// Description : Directed self-checking bench for noc_packet_sink.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_noc_packet_sink;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rx = 1'b0;
    logic [15:0] data_i = 16'h0;
    logic        credit_o;
    logic [31:0] recv_addr_in = 32'h0;
    logic        recv_cmd_in = 1'b0;
    logic [31:0] recv_size_out;
    logic [31:0] recv_addr_out;
    logic [7:0]  state_out;
    logic        irq_size_out;
    logic        irq_done_out;
    logic [31:0] mem_addr_out;
    logic [31:0] mem_data_out;
    logic [3:0]  mem_wb_out;
`ifdef DEST_CHECK_EN
    logic [15:0] drop_count_out;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [3:0]  wr_wb[$];
    int          done_cycles = 0;

    noc_packet_sink dut (
        .clock         (clock),
        .reset         (reset),
        .rx            (rx),
        .data_i        (data_i),
        .credit_o      (credit_o),
        .recv_addr_in  (recv_addr_in),
        .recv_cmd_in   (recv_cmd_in),
        .recv_size_out (recv_size_out),
        .recv_addr_out (recv_addr_out),
        .state_out     (state_out),
        .irq_size_out  (irq_size_out),
        .irq_done_out  (irq_done_out),
        .mem_addr_out  (mem_addr_out),
        .mem_data_out  (mem_data_out),
        .mem_wb_out    (mem_wb_out)
`ifdef DEST_CHECK_EN
        ,
        .drop_count_out(drop_count_out)
`endif
    );

    always #5 clock = ~clock;

    // Record every RAM write and every cycle of irq_done.
    always @(negedge clock) begin
        if (mem_wb_out !== 4'h0) begin
            wr_addr.push_back(mem_addr_out);
            wr_data.push_back(mem_data_out);
            wr_wb.push_back(mem_wb_out);
        end
        if (irq_done_out === 1'b1) done_cycles++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_wb.delete();
    endtask

    task automatic send(input logic [15:0] f);
        int t;
        t = 0;
        while (credit_o !== 1'b1 && t < 100) begin
            tick();
            t++;
        end
        if (t >= 100) begin
            n_checks++;
            $display("FAIL send_credit_timeout: credit_o=%b required 1", credit_o);
        end
        rx = 1'b1;
        data_i = f;
        tick();
        rx = 1'b0;
        data_i = 16'h0;
    endtask

    task automatic wait_irq_size(input string name);
        int t;
        t = 0;
        while (irq_size_out !== 1'b1 && t < 50) begin
            tick();
            t++;
        end
        n_checks++;
        if (irq_size_out !== 1'b1)
            $display("FAIL %s_irq_size: got %b required 1", name, irq_size_out);
        else n_pass++;
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while (irq_done_out !== 1'b1 && t < 100) begin
            tick();
            t++;
        end
        n_checks++;
        if (irq_done_out !== 1'b1)
            $display("FAIL %s_irq_done: got %b required 1", name, irq_done_out);
        else n_pass++;
    endtask

    task automatic issue_cmd(input logic [31:0] a);
        recv_addr_in = a;
        recv_cmd_in  = 1'b1;
        tick();
        recv_cmd_in  = 1'b0;
    endtask

    task automatic check_write(input string name, input int idx,
                               input logic [31:0] ea, input logic [31:0] ed);
        n_checks++;
        if (wr_addr.size() <= idx) begin
            $display("FAIL %s: write %0d missing (got %0d writes)", name, idx, wr_addr.size());
        end else if (wr_addr[idx] !== ea || wr_data[idx] !== ed || wr_wb[idx] !== 4'hF) begin
            $display("FAIL %s: got addr=%h data=%h wb=%h required addr=%h data=%h wb=f",
                     name, wr_addr[idx], wr_data[idx], wr_wb[idx], ea, ed);
        end else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick(); tick();
        n_checks++;
        if (credit_o !== 1'b0 || state_out !== 8'd0 || irq_size_out !== 1'b0 ||
            irq_done_out !== 1'b0 || mem_wb_out !== 4'h0 || recv_size_out !== 32'd0 ||
            recv_addr_out !== 32'd0 || mem_addr_out !== 32'd0 || mem_data_out !== 32'd0)
            $display("FAIL reset_outputs: credit=%b state=%h irqs=%b%b wb=%h required all 0",
                     credit_o, state_out, irq_size_out, irq_done_out, mem_wb_out);
        else n_pass++;
        reset = 1'b0;
        tick();
        n_checks++;
        if (credit_o !== 1'b1) $display("FAIL reset_credit_release: got %b required 1", credit_o);
        else n_pass++;
    endtask

    task automatic test_basic();
        int d0;
        clear_log();
        send(16'h0000);
        send(16'h0004);
        wait_irq_size("basic");
        n_checks++;
        if (recv_size_out !== 32'd4 || state_out !== 8'd2)
            $display("FAIL basic_size: got size=%0d state=%0d required size=4 state=2", recv_size_out, state_out);
        else n_pass++;
        issue_cmd(32'h4000_0100);
        n_checks++;
        if (irq_size_out !== 1'b0 || state_out !== 8'd3)
            $display("FAIL basic_cmd: got irq_size=%b state=%0d required 0/3", irq_size_out, state_out);
        else n_pass++;
        d0 = done_cycles;
        send(16'hAAAA);
        send(16'hBBBB);
        send(16'hCCCC);
        send(16'hDDDD);
        wait_done("basic");
        tick();
        tick();
        check_write("basic_w0", 0, 32'h40, 32'hAAAA_BBBB);
        check_write("basic_w1", 1, 32'h41, 32'hCCCC_DDDD);
        n_checks++;
        if (wr_addr.size() !== 2 || recv_addr_out !== 32'h4000_0108 ||
            done_cycles - d0 !== 1 || state_out !== 8'd0)
            $display("FAIL basic_end: got writes=%0d addr=%h done_cycles=%0d state=%0d required 2/40000108/1/0",
                     wr_addr.size(), recv_addr_out, done_cycles - d0, state_out);
        else n_pass++;
    endtask

    task automatic test_odd();
        clear_log();
        send(16'h0000);
        send(16'h0003);
        wait_irq_size("odd");
        issue_cmd(32'h0000_0200);
        send(16'h1111);
        send(16'h2222);
        send(16'h3333);
        wait_done("odd");
        tick();
        check_write("odd_w0", 0, 32'h80, 32'h1111_2222);
        check_write("odd_w1", 1, 32'h81, 32'h3333_0000);
        n_checks++;
        if (wr_addr.size() !== 2 || recv_addr_out !== 32'h0000_0208)
            $display("FAIL odd_end: got writes=%0d addr=%h required 2/00000208", wr_addr.size(), recv_addr_out);
        else n_pass++;
    endtask

    task automatic test_size0();
        clear_log();
        send(16'h0000);
        send(16'h0000);
        wait_irq_size("size0");
        recv_addr_in = 32'h0000_0300;
        recv_cmd_in  = 1'b1;
        tick();
        recv_cmd_in  = 1'b0;
        n_checks++;
        if (irq_done_out !== 1'b1 || state_out !== 8'd4)
            $display("FAIL size0_done: got irq_done=%b state=%0d required 1/4", irq_done_out, state_out);
        else n_pass++;
        tick();
        tick();
        n_checks++;
        if (irq_done_out !== 1'b0 || state_out !== 8'd0 || wr_addr.size() !== 0)
            $display("FAIL size0_end: got irq_done=%b state=%0d writes=%0d required 0/0/0",
                     irq_done_out, state_out, wr_addr.size());
        else n_pass++;
    endtask

    task automatic test_backpressure();
        clear_log();
        send(16'h0000);
        send(16'h0008);
        wait_irq_size("bp");
        send(16'h0101);
        send(16'h0202);
        send(16'h0303);
        send(16'h0404);
        n_checks++;
        if (credit_o !== 1'b0) $display("FAIL bp_credit_low: got %b required 0", credit_o);
        else n_pass++;
        tick();
        tick();
        n_checks++;
        if (credit_o !== 1'b0 || state_out !== 8'd2)
            $display("FAIL bp_hold: got credit=%b state=%0d required 0/2", credit_o, state_out);
        else n_pass++;
        issue_cmd(32'h0000_1000);
        send(16'h0505);
        send(16'h0606);
        send(16'h0707);
        send(16'h0808);
        wait_done("bp");
        tick();
        check_write("bp_w0", 0, 32'h400, 32'h0101_0202);
        check_write("bp_w1", 1, 32'h401, 32'h0303_0404);
        check_write("bp_w2", 2, 32'h402, 32'h0505_0606);
        check_write("bp_w3", 3, 32'h403, 32'h0707_0808);
    endtask

    task automatic test_reset_mid_copy();
        clear_log();
        send(16'h0000);
        send(16'h0004);
        wait_irq_size("rmc");
        issue_cmd(32'h0000_0000);
        send(16'h1111);
        send(16'h2222);
        tick(); tick(); tick();
        check_write("rmc_first", 0, 32'h0, 32'h1111_2222);
        send(16'h3333);
        reset = 1'b1;
        tick();
        n_checks++;
        if (state_out !== 8'd0 || irq_size_out !== 1'b0 || irq_done_out !== 1'b0 ||
            mem_wb_out !== 4'h0 || credit_o !== 1'b0 || recv_addr_out !== 32'h0)
            $display("FAIL rmc_reset: got state=%0d irqs=%b%b wb=%h credit=%b addr=%h required all 0",
                     state_out, irq_size_out, irq_done_out, mem_wb_out, credit_o, recv_addr_out);
        else n_pass++;
        reset = 1'b0;
        tick();
        n_checks++;
        if (credit_o !== 1'b1) $display("FAIL rmc_credit: got %b required 1", credit_o);
        else n_pass++;
        send(16'h4444);
        tick(); tick(); tick();
        n_checks++;
        if (wr_addr.size() !== 1 || state_out !== 8'd1)
            $display("FAIL rmc_after: got writes=%0d state=%0d required 1/1", wr_addr.size(), state_out);
        else n_pass++;
    endtask

`ifdef DEST_CHECK_EN
    task automatic test_drop();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        clear_log();
        send(16'h0101);
        send(16'h0002);
        send(16'h1234);
        send(16'h5678);
        tick(); tick(); tick(); tick();
        n_checks++;
        if (wr_addr.size() !== 0 || drop_count_out !== 16'd1 || state_out !== 8'd0 ||
            irq_size_out !== 1'b0)
            $display("FAIL drop_packet: got writes=%0d drops=%0d state=%0d irq_size=%b required 0/1/0/0",
                     wr_addr.size(), drop_count_out, state_out, irq_size_out);
        else n_pass++;
        send(16'h0000);
        send(16'h0002);
        wait_irq_size("drop_next");
        issue_cmd(32'h0000_0000);
        send(16'hBEEF);
        send(16'hCAFE);
        wait_done("drop_next");
        tick();
        check_write("drop_next_w0", 0, 32'h0, 32'hBEEF_CAFE);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_odd();
        test_size0();
        test_backpressure();
        test_reset_mid_copy();
`ifdef DEST_CHECK_EN
        test_drop();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_noc_packet_sink
`default_nettype wire
